// File: rtl/oled_spi_tx.sv
// SPI mode-3 byte transmitter for the SSD1331 OLED link: MSB first, per-byte data/command flag,
// zero-gap bursts while the upstream keeps bytes coming, cs released on the byte flagged last.
module oled_spi_tx #(
    parameter int CLK_DIV  = 2,
    parameter int CS_SETUP = 1,
    parameter int CS_HOLD  = 1,
    parameter int CS_GAP   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_dc,
    input  logic       in_last,
    output logic       sclk,
    output logic       sdata,
    output logic       cs,
    output logic       d_cn,
    output logic       busy,
    output logic       frame_done
);

    localparam int DIV_W = $clog2(CLK_DIV) + 1;
    localparam int TMAX  = (CS_SETUP > CS_HOLD) ? ((CS_SETUP > CS_GAP) ? CS_SETUP : CS_GAP)
                                                : ((CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP);
    localparam int TMR_W = $clog2(TMAX) + 1;

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [TMR_W-1:0] SETUP_LAST = TMR_W'(CS_SETUP - 1);
    localparam logic [TMR_W-1:0] HOLD_LAST  = TMR_W'(CS_HOLD - 1);
    localparam logic [TMR_W-1:0] GAP_LAST   = TMR_W'(CS_GAP - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, WAIT, HOLD, GAP} state_t;

    state_t             state_q, state_n;
    logic [DIV_W-1:0]   div_q, div_n;
    logic               phase_q, phase_n;
    logic [2:0]         bit_q, bit_n;
    logic [TMR_W-1:0]   tmr_q, tmr_n;
    logic [7:0]         shreg_q, shreg_n;
    logic               dc_q, dc_n;
    logic               last_q, last_n;
    logic               load;
    logic               byte_end;
    logic               hs;
    logic               cs_n, sclk_n, sdata_n, d_cn_n, busy_n, frame_done_n;

    // The last cycle of bit0's high phase is the only point a following byte can chain in
    assign byte_end = (state_q == SHIFT) && (div_q == DIV_LAST) && phase_q && (bit_q == 3'd0);
    assign in_ready = !reset && ((state_q == IDLE) || (state_q == WAIT) || (byte_end && !last_q));
    assign hs       = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cs         <= 1'b1;
            sclk       <= 1'b1;
            sdata      <= 1'b0;
            d_cn       <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_n;
            cs         <= cs_n;
            sclk       <= sclk_n;
            sdata      <= sdata_n;
            d_cn       <= d_cn_n;
            busy       <= busy_n;
            frame_done <= frame_done_n;
        end
        div_q   <= div_n;
        phase_q <= phase_n;
        bit_q   <= bit_n;
        tmr_q   <= tmr_n;
        shreg_q <= shreg_n;
        dc_q    <= dc_n;
        last_q  <= last_n;
    end

    always_comb begin
        state_n = state_q;
        div_n   = div_q;
        phase_n = phase_q;
        bit_n   = bit_q;
        tmr_n   = tmr_q;
        shreg_n = shreg_q;
        dc_n    = dc_q;
        last_n  = last_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (hs) begin
                    state_n = SETUP;
                    tmr_n   = '0;
                    load    = 1'b1;
                end
            end
            SETUP: begin
                if (tmr_q == SETUP_LAST) begin
                    state_n = SHIFT;
                    div_n   = '0;
                    phase_n = 1'b0;
                    bit_n   = 3'd7;
                end else begin
                    tmr_n = tmr_q + TMR_W'(1);
                end
            end
            SHIFT: begin
                if (div_q != DIV_LAST) begin
                    div_n = div_q + DIV_W'(1);
                end else begin
                    div_n = '0;
                    if (!phase_q) begin
                        phase_n = 1'b1;
                    end else if (bit_q != 3'd0) begin
                        phase_n = 1'b0;
                        bit_n   = bit_q - 3'd1;
                        shreg_n = {shreg_q[6:0], 1'b0};
                    end else if (last_q) begin
                        state_n = HOLD;
                        tmr_n   = '0;
                    end else if (hs) begin
                        load    = 1'b1;
                        phase_n = 1'b0;
                        bit_n   = 3'd7;
                    end else begin
                        state_n = WAIT;
                    end
                end
            end
            WAIT: begin
                if (hs) begin
                    state_n = SHIFT;
                    load    = 1'b1;
                    div_n   = '0;
                    phase_n = 1'b0;
                    bit_n   = 3'd7;
                end
            end
            HOLD: begin
                if (tmr_q == HOLD_LAST) begin
                    state_n = GAP;
                    tmr_n   = '0;
                end else begin
                    tmr_n = tmr_q + TMR_W'(1);
                end
            end
            GAP: begin
                if (tmr_q == GAP_LAST) state_n = IDLE;
                else                   tmr_n   = tmr_q + TMR_W'(1);
            end
            default: state_n = IDLE;
        endcase
        if (load) begin
            shreg_n = in_data;
            dc_n    = in_dc;
            last_n  = in_last;
        end
    end

    // Pins are registered from the next state so they line up with the state they describe
    always_comb begin
        cs_n         = !((state_n == SETUP) || (state_n == SHIFT) ||
                         (state_n == WAIT)  || (state_n == HOLD));
        sclk_n       = !((state_n == SHIFT) && !phase_n);
        sdata_n      = (state_n == SHIFT) ? shreg_n[7] : sdata;
        d_cn_n       = ((state_n == SETUP) || (state_n == SHIFT)) ? dc_n : d_cn;
        busy_n       = (state_n != IDLE);
        frame_done_n = (state_q == HOLD) && (state_n == GAP);
    end

endmodule

// File: tb/tb_oled_spi_tx.sv
// Bench for oled_spi_tx: a per-cycle expected pin timeline built from transaction lists,
// plus an SPI decoder whose captured bytes and burst lengths are pinned to literal values.
`timescale 1ns/1ps
module tb_oled_spi_tx;

    localparam int N        = 1024;
    localparam int CS_SETUP = 1;
    localparam int CS_HOLD  = 1;
    localparam int CS_GAP   = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset[2], in_valid[2], in_ready[2], in_dc[2], in_last[2];
    logic       sclk[2], sdata[2], cs[2], d_cn[2], busy[2], frame_done[2];
    logic [7:0] in_data[2];

    oled_spi_tx #(.CLK_DIV(2), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .CS_GAP(CS_GAP)) u_dut0 (
        .clk(clk), .reset(reset[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .in_dc(in_dc[0]), .in_last(in_last[0]), .sclk(sclk[0]),
        .sdata(sdata[0]), .cs(cs[0]), .d_cn(d_cn[0]), .busy(busy[0]), .frame_done(frame_done[0]));

    oled_spi_tx #(.CLK_DIV(1), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .CS_GAP(CS_GAP)) u_dut1 (
        .clk(clk), .reset(reset[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .in_dc(in_dc[1]), .in_last(in_last[1]), .sclk(sclk[1]),
        .sdata(sdata[1]), .cs(cs[1]), .d_cn(d_cn[1]), .busy(busy[1]), .frame_done(frame_done[1]));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected pins per unit/cycle: 0 cs,1 sclk,2 sdata,3 d_cn,4 in_ready,5 busy,6 frame_done; 2 = unchecked
    logic [1:0] ex [2][N][7];
    logic       vld_s[2][N], dc_s[2][N], last_s[2][N], rst_s[2][N];
    logic [7:0] dat_s[2][N];
    logic [7:0] tb_b[4];
    logic       tb_dc[4];
    int         tb_dl[4];
    logic       mdl_sd[2], mdl_dc[2];
    string      sig_name[7] = '{"cs", "sclk", "sdata", "d_cn", "in_ready", "busy", "frame_done"};

    int checks = 0;
    int failures = 0;
    int end_cyc = N - 1;
    bit running = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic se(input int u, input int c, input int cs_e, input int sc, input int sd,
                      input int dcn, input int rdy, input int bsy, input int fd);
        if (c >= 0 && c < N) begin
            ex[u][c][0] = 2'(cs_e); ex[u][c][1] = 2'(sc);  ex[u][c][2] = 2'(sd);
            ex[u][c][3] = 2'(dcn);  ex[u][c][4] = 2'(rdy); ex[u][c][5] = 2'(bsy);
            ex[u][c][6] = 2'(fd);
        end
    endtask

    task automatic idle(input int u, input int from, input int to);
        for (int c = from; c < to; c++) se(u, c, 1, 1, mdl_sd[u], mdl_dc[u], 1, 0, 0);
    endtask

    // Timeline of one burst of n bytes (tb_b/tb_dc, tb_dl[k] = cycles byte k arrives after the
    // previous byte ends); first byte handshakes at cycle s; g = first idle cycle afterwards.
    task automatic plan(input int u, input int s, input int d, input int n, output int g);
        int b, e, h, hp, pres, bitn, sc;
        se(u, s, 1, 1, mdl_sd[u], mdl_dc[u], 1, 0, 0);
        vld_s[u][s] = 1'b1; dat_s[u][s] = tb_b[0]; dc_s[u][s] = tb_dc[0]; last_s[u][s] = (n == 1);
        for (int i = 1; i <= CS_SETUP; i++) se(u, s + i, 0, 1, mdl_sd[u], tb_dc[0], 0, 1, 0);
        b = s + 1 + CS_SETUP; hp = s; e = b;
        for (int k = 0; k < n; k++) begin
            for (int j = 0; j < 16 * d; j++) begin
                bitn = 7 - j / (2 * d);
                sc   = ((j % (2 * d)) >= d) ? 1 : 0;
                se(u, b + j, 0, sc, tb_b[k][bitn], tb_dc[k], (j == 16 * d - 1 && k != n - 1) ? 1 : 0, 1, 0);
            end
            mdl_sd[u] = tb_b[k][0];
            mdl_dc[u] = tb_dc[k];
            e = b + 16 * d - 1;
            if (k < n - 1) begin
                h    = e + tb_dl[k + 1];
                pres = (tb_dl[k + 1] == 0) ? hp + 1 : h;
                for (int c = pres; c <= h; c++) begin
                    vld_s[u][c] = 1'b1; dat_s[u][c] = tb_b[k + 1];
                    dc_s[u][c] = tb_dc[k + 1]; last_s[u][c] = (k + 1 == n - 1);
                end
                for (int w = 1; w <= tb_dl[k + 1]; w++) se(u, e + w, 0, 1, mdl_sd[u], mdl_dc[u], 1, 1, 0);
                hp = h;
                b  = h + 1;
            end
        end
        for (int i = 1; i <= CS_HOLD; i++) se(u, e + i, 0, 1, mdl_sd[u], mdl_dc[u], 0, 1, 0);
        for (int i = 1; i <= CS_GAP; i++)
            se(u, e + CS_HOLD + i, 1, 1, mdl_sd[u], mdl_dc[u], 0, 1, (i == 1) ? 1 : 0);
        g = e + CS_HOLD + CS_GAP + 1;
    endtask

    task automatic drive(input int c);
        for (int u = 0; u < 2; u++) begin
            reset[u]    = rst_s[u][c];
            in_valid[u] = vld_s[u][c];
            if (vld_s[u][c]) begin
                in_data[u] = dat_s[u][c]; in_dc[u] = dc_s[u][c]; in_last[u] = last_s[u][c];
            end else begin
                in_data[u] = 8'(c * 37 + u * 11); in_dc[u] = c[0]; in_last[u] = c[1];
            end
        end
    endtask

    function automatic logic get_act(input int u, input int k);
        case (k)
            0: return cs[u];
            1: return sclk[u];
            2: return sdata[u];
            3: return d_cn[u];
            4: return in_ready[u];
            5: return busy[u];
            default: return frame_done[u];
        endcase
    endfunction

    always @(negedge clk) begin
        if (running && cyc < end_cyc) begin
            for (int u = 0; u < 2; u++)
                for (int k = 0; k < 7; k++)
                    if (ex[u][cyc][k] < 2) begin
                        checks++;
                        if (get_act(u, k) !== ex[u][cyc][k][0]) begin
                            failures++;
                            $display("FAIL u%0d cycle %0d %s actual=%b required=%0d",
                                     u, cyc, sig_name[k], get_act(u, k), ex[u][cyc][k]);
                        end
                    end
        end
    end

    // SPI decoder: bits taken on sclk rises while cs low; burst length recorded at cs release
    logic       pcs[2] = '{1'b1, 1'b1};
    logic       psc[2] = '{1'b1, 1'b1};
    logic [7:0] shm[2];
    int         run[2] = '{0, 0}, rises[2] = '{0, 0}, nb[2] = '{0, 0};
    int         len_a[2][16], rise_a[2][16];
    logic [7:0] byte_a[2][16];
    logic       bdc_a[2][16];
    int         len_n[2] = '{0, 0}, byte_n[2] = '{0, 0}, fd_n[2] = '{0, 0};

    always @(negedge clk) begin
        if (running) begin
            for (int u = 0; u < 2; u++) begin
                if (frame_done[u] === 1'b1) fd_n[u]++;
                if (cs[u] === 1'b0) begin
                    run[u]++;
                    if (psc[u] === 1'b0 && sclk[u] === 1'b1) begin
                        rises[u]++;
                        shm[u] = {shm[u][6:0], sdata[u]};
                        nb[u]++;
                        if (nb[u] == 8) begin
                            if (byte_n[u] < 16) begin
                                byte_a[u][byte_n[u]] = shm[u];
                                bdc_a[u][byte_n[u]]  = d_cn[u];
                            end
                            byte_n[u]++;
                            nb[u] = 0;
                        end
                    end
                end else if (pcs[u] === 1'b0) begin
                    if (len_n[u] < 16) begin
                        len_a[u][len_n[u]]  = run[u];
                        rise_a[u][len_n[u]] = rises[u];
                    end
                    len_n[u]++;
                    run[u] = 0; rises[u] = 0; nb[u] = 0;
                end
                pcs[u] = cs[u];
                psc[u] = sclk[u];
            end
        end
    end

    int exp_len0[5]  = '{34, 98, 108, 66, 20};
    int exp_rise0[5] = '{8, 24, 24, 16, 5};
    logic [7:0] exp_byte0[9] = '{8'hA5, 8'h15, 8'h00, 8'h5F, 8'h15, 8'h00, 8'h5F, 8'h75, 8'hFF};
    logic exp_dc0[9] = '{0, 0, 0, 0, 0, 0, 0, 0, 1};

    initial begin
        int s, g, r;
        for (int u = 0; u < 2; u++)
            for (int c = 0; c < N; c++) begin
                vld_s[u][c] = 0; dc_s[u][c] = 0; last_s[u][c] = 0; rst_s[u][c] = 0; dat_s[u][c] = 0;
                for (int k = 0; k < 7; k++) ex[u][c][k] = 2'd2;
            end
        for (int u = 0; u < 2; u++) begin
            mdl_sd[u] = 0; mdl_dc[u] = 0;
            for (int c = 0; c < 4; c++) rst_s[u][c] = 1;
            for (int c = 1; c < 4; c++) se(u, c, 1, 1, 0, 0, 0, 0, 0);
        end

        // Unit 0 (CLK_DIV=2). Test 1: single 0xA5 command byte
        idle(0, 4, 8);
        s = 8;
        tb_b[0] = 8'hA5; tb_dc[0] = 0; tb_dl[0] = 0;
        plan(0, s, 2, 1, g);
        chk("model_t1_idle_after", g - s, 37);
        idle(0, g, g + 5); s = g + 5;
        // Test 2: zero-gap three-byte burst
        tb_b[0] = 8'h15; tb_b[1] = 8'h00; tb_b[2] = 8'h5F;
        tb_dc[0] = 0; tb_dc[1] = 0; tb_dc[2] = 0;
        tb_dl[0] = 0; tb_dl[1] = 0; tb_dl[2] = 0;
        plan(0, s, 2, 3, g);
        idle(0, g, g + 5); s = g + 5;
        // Test 3: second byte arrives 10 cycles late
        tb_dl[1] = 10;
        plan(0, s, 2, 3, g);
        idle(0, g, g + 5); s = g + 5;
        // Test 4: command then data byte
        tb_b[0] = 8'h75; tb_dc[0] = 0; tb_b[1] = 8'hFF; tb_dc[1] = 1; tb_dl[1] = 0;
        plan(0, s, 2, 2, g);
        idle(0, g, g + 5); s = g + 5;
        // Test 5: reset during bit 3
        tb_b[0] = 8'h3C; tb_dc[0] = 1;
        plan(0, s, 2, 1, g);
        r = s + 20;
        for (int c = r; c <= r + 2; c++) rst_s[0][c] = 1;
        mdl_sd[0] = 0; mdl_dc[0] = 0;
        for (int c = r + 1; c <= r + 2; c++) se(0, c, 1, 1, 0, 0, 0, 0, 0);
        end_cyc = r + 3 + 20;
        idle(0, r + 3, end_cyc);

        // Unit 1 (CLK_DIV=1). Test 6: single 0x81
        idle(1, 4, 20);
        tb_b[0] = 8'h81; tb_dc[0] = 0;
        plan(1, 20, 1, 1, g);
        chk("model_t6_idle_after", g - 20, 21);
        idle(1, g, end_cyc);

        drive(0);
        running = 1'b1;
        for (int i = 1; i < end_cyc + 2; i++) begin
            @(posedge clk);
            #1;
            drive((cyc < N) ? cyc : N - 1);
        end
        running = 1'b0;

        chk("u0_bursts", len_n[0], 5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("u0_cs_low_len%0d", i), len_a[0][i], exp_len0[i]);
            chk($sformatf("u0_sclk_rises%0d", i), rise_a[0][i], exp_rise0[i]);
        end
        chk("u0_bytes", byte_n[0], 9);
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("u0_byte%0d", i), int'(byte_a[0][i]), int'(exp_byte0[i]));
            chk($sformatf("u0_byte%0d_dc", i), int'(bdc_a[0][i]), int'(exp_dc0[i]));
        end
        chk("u0_frame_done_pulses", fd_n[0], 4);
        chk("u1_bursts", len_n[1], 1);
        chk("u1_cs_low_len", len_a[1][0], 18);
        chk("u1_sclk_rises", rise_a[1][0], 8);
        chk("u1_bytes", byte_n[1], 1);
        chk("u1_byte0", int'(byte_a[1][0]), 8'h81);
        chk("u1_frame_done_pulses", fd_n[1], 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
